ahb_apb_bridge_mp: RTL and testbench
====================================

# ahb_apb_bridge_mp

Single-clock AHB-Lite to APB4 bridge with a parametrised number of APB slave selects. It sits behind an AHB interconnect slot and fans one AHB port out to N_SLV peripherals. It adds three things the single-slave bridge lacks: per-slave address decode, an APB wait-state timeout that returns an AHB ERROR, and a sleep request/acknowledge handshake that quiesces the bridge between transfers.

## Interface
- DATA_WIDTH, 32: AHB/APB data width; must be 32 or 64.
- ADDR_WIDTH, 32: AHB/APB address width.
- N_SLV, 4: number of APB slaves, 1..16.
- SLV_AW, 12: bits of address space per slave. The slave index is IDX = i_haddr[SLV_AW +: IW], where IW = max(1, clog2(N_SLV)).
- TIMEOUT, 255: maximum ACCESS cycles before abort; 0 disables the timeout.

Clock and reset:
- i_clk  in  1  single clock for both AHB and APB.
- i_rst  in  1  asynchronous, active-high reset.

Sleep handshake:
- i_sleep_req  in  1  request to quiesce.
- o_sleep_ack  out  1  high while in SLEEP.

AHB side:
- i_hselx  in  1  slot select.
- i_hready  in  1  bus HREADY.
- i_htrans  in  2  transfer type.
- i_hsize  in  3  transfer size.
- i_hwrite  in  1  write.
- i_haddr  in  ADDR_WIDTH  address.
- i_hwdata  in  DATA_WIDTH  write data.
- o_hreadyout  out  1  ready.
- o_hresp  out  1  1 = ERROR.
- o_hrdata  out  DATA_WIDTH  read data.

APB side:
- i_prdata  in  N_SLV*DATA_WIDTH  slave k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_pready  in  N_SLV  per-slave ready.
- i_pslverr  in  N_SLV  per-slave error.
- o_psel  out  N_SLV  one-hot select.
- o_penable  out  1.
- o_pwrite  out  1.
- o_paddr  out  ADDR_WIDTH.
- o_pwdata  out  DATA_WIDTH.
- o_pstrb  out  DATA_WIDTH/8.

## Operation
- Accept a transfer when all of the following hold: i_hselx=1, i_hready=1, i_htrans[1]=1 (NONSEQ or SEQ), and state is IDLE or SLEEP. IDLE and BUSY transfers are ignored with an OKAY response.
- On accept, register haddr, hwrite, hsize and IDX.
- States and transitions:
  - IDLE: accept, go to CAPT.
  - CAPT: latch i_hwdata into o_pwdata. If IDX >= N_SLV or hsize > log2(DATA_WIDTH/8), go to ERR1. Otherwise go to SETUP.
  - SETUP: o_psel[IDX]=1, o_penable=0. Go to ACCESS.
  - ACCESS: o_penable=1. On i_pready[IDX]=1: if i_pslverr[IDX]=1 go to ERR1, else latch o_hrdata (reads only) and go to IDLE. On timeout expiry, drop psel/penable and go to ERR1.
  - ERR1: hresp=1, hreadyout=0. Go to ERR2.
  - ERR2: hresp=1, hreadyout=1. Go to SLEEP if the sleep flag is set, else IDLE.
  - SLEEP: o_sleep_ack=1. An accepted transfer goes to ERR1 with the sleep flag set, and no APB access is made. When i_sleep_req=0, go to IDLE.
- o_hreadyout=0 in CAPT, SETUP, ACCESS and ERR1; 1 in every other state. o_hresp=1 only in ERR1 and ERR2.
- Strobes: for writes, o_pstrb = ((1 << (1 << hsize)) - 1) << (haddr mod (DATA_WIDTH/8), aligned down to the size). For reads, o_pstrb=0.
- o_paddr carries the full registered haddr. o_pwrite, o_paddr, o_pwdata and o_pstrb are held stable from SETUP through ACCESS.
- Sleep entry happens only from IDLE, with i_sleep_req=1 and no accept in the same cycle. If an accept and a sleep request occur together, the accept wins and sleep is entered after completion. A request raised mid-transfer is honoured after the transfer returns to IDLE.
- Timeout counter:
  - Cleared on entering ACCESS.
  - Increments each ACCESS cycle with pready=0.
  - Abort when the count equals TIMEOUT-1 and pready=0, so ACCESS lasts at most TIMEOUT cycles.

## Timing
- Reset values: o_hreadyout=1; all other outputs 0 (o_hresp, o_hrdata, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_sleep_ack). State is IDLE and the sleep flag is clear.
- Reset mid-transfer: outputs return to reset values immediately, with no APB completion.
- Edge E0 samples the address phase. Then:
  - CAPT in cycle 1.
  - SETUP in cycle 2.
  - ACCESS from cycle 3.
  - IDLE with hreadyout=1 in the cycle after the edge that samples pready=1.
- Minimum data phase is 4 cycles. Each APB wait state adds one cycle.
- A back-to-back transfer is accepted in the IDLE cycle that completes the previous one.
- ERROR response: 2 cycles, ERR1 then ERR2. For decode and size errors, ERR1 directly follows CAPT.
- o_hrdata is valid when hreadyout returns high and is held until the next read completes.
- o_sleep_ack rises 1 cycle after i_sleep_req is sampled in IDLE and falls 1 cycle after i_sleep_req is sampled low.

## Test plan
- N_SLV=4, SLV_AW=12, word write to 0x2004 with hwdata 0xDEADBEEF and pready tied 1:
  - o_psel=0b0100, o_paddr=0x2004, o_pwdata=0xDEADBEEF, o_pstrb=0xF.
  - hreadyout high 4 cycles after the address edge.
- Byte read at 0x1003 with pready delayed 3 cycles and prdata[1]=0x11223344:
  - o_pstrb=0, 3 extra wait cycles.
  - o_hrdata=0x11223344 with OKAY.
- Halfword write at 0x3002 → o_pstrb=0b1100. Read with pslverr[3]=1 → 2-cycle ERROR, hresp=1 in both cycles.
- TIMEOUT=8, pready held 0:
  - psel and penable drop after 8 ACCESS cycles, then 2-cycle ERROR.
  - Next transfer completes normally.
- N_SLV=3, access at 0x3000 → no psel toggles, ERROR response. hsize=3 on DATA_WIDTH=32 → ERROR response.
- Sleep handshake:
  - Raise i_sleep_req during an ACCESS → transfer completes, then o_sleep_ack=1 one cycle later.
  - Transfer during SLEEP → ERROR and no psel, o_sleep_ack stays 1.
  - Drop i_sleep_req → o_sleep_ack=0 one cycle later.
  - Assert i_rst during ACCESS → outputs return to reset values.

Source files
------------

// File: rtl/ahb_apb_bridge_mp.sv
// ahb_apb_bridge_mp: AHB-Lite to APB4 bridge with per-slave decode, APB timeout and sleep handshake
module ahb_apb_bridge_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_SLV      = 4,
  parameter int SLV_AW     = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_sleep_req,
  output logic                        o_sleep_ack,
  input  logic                        i_hselx,
  input  logic                        i_hready,
  input  logic [1:0]                  i_htrans,
  input  logic [2:0]                  i_hsize,
  input  logic                        i_hwrite,
  input  logic [ADDR_WIDTH-1:0]       i_haddr,
  input  logic [DATA_WIDTH-1:0]       i_hwdata,
  output logic                        o_hreadyout,
  output logic                        o_hresp,
  output logic [DATA_WIDTH-1:0]       o_hrdata,
  input  logic [N_SLV*DATA_WIDTH-1:0] i_prdata,
  input  logic [N_SLV-1:0]            i_pready,
  input  logic [N_SLV-1:0]            i_pslverr,
  output logic [N_SLV-1:0]            o_psel,
  output logic                        o_penable,
  output logic                        o_pwrite,
  output logic [ADDR_WIDTH-1:0]       o_paddr,
  output logic [DATA_WIDTH-1:0]       o_pwdata,
  output logic [DATA_WIDTH/8-1:0]     o_pstrb
);
  localparam int IW = N_SLV > 1 ? $clog2(N_SLV) : 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, CAPT, SETUP, ACCESS, ERR1, ERR2, SLEEP} state_t;

  state_t state, nxt;
  logic [2:0] size;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [OW-1:0] off;
  logic flag, accept, bad, rdy, err, tmo;
  logic [DATA_WIDTH-1:0] rd_a [N_SLV];
  logic unused_htrans;

  for (genvar k = 0; k < N_SLV; k++) begin : g_rd
    assign rd_a[k] = i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign unused_htrans = i_htrans[0];
  assign accept = i_hselx & i_hready & i_htrans[1] & (state == IDLE | state == SLEEP);
  assign bad = (int'(idx) >= N_SLV) | (int'(size) > OW);
  assign rdy = i_pready[idx];
  assign err = i_pslverr[idx];
  assign tmo = TIMEOUT != 0 && int'(cnt) == TIMEOUT - 1;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else state <= nxt;
  end

  // Next-state: accepts win over sleep entry; sleeping accepts go straight to an error
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept ? CAPT : i_sleep_req ? SLEEP : IDLE;
      CAPT:    nxt = bad ? ERR1 : SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  nxt = rdy ? (err ? ERR1 : IDLE) : tmo ? ERR1 : ACCESS;
      ERR1:    nxt = ERR2;
      ERR2:    nxt = flag ? SLEEP : IDLE;
      SLEEP:   nxt = accept ? ERR1 : i_sleep_req ? SLEEP : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; ack stays up through an error taken while asleep
  always_comb begin
    o_hreadyout = !(state inside {CAPT, SETUP, ACCESS, ERR1});
    o_hresp = state inside {ERR1, ERR2};
    o_psel = (state == SETUP || state == ACCESS) ? N_SLV'(1) << idx : '0;
    o_penable = state == ACCESS;
    o_sleep_ack = state == SLEEP || flag;
  end

  // Byte lanes of a write, with the offset aligned down to the transfer size
  always_comb begin
    off = o_paddr[OW-1:0] & ~OW'((1 << size) - 1);
    o_pstrb = o_pwrite ? SW'(((1 << (1 << size)) - 1) << off) : '0;
  end

  // Address-phase capture, write data, read data, wait counter and sleep flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_paddr <= '0;
      o_pwrite <= 1'b0;
      size <= '0;
      idx <= '0;
      o_pwdata <= '0;
      o_hrdata <= '0;
      cnt <= '0;
      flag <= 1'b0;
    end else begin
      if (accept) begin
        o_paddr <= i_haddr;
        o_pwrite <= i_hwrite;
        size <= i_hsize;
        idx <= i_haddr[SLV_AW +: IW];
      end
      if (state == CAPT) o_pwdata <= i_hwdata;
      if (state == ACCESS && rdy && !err && !o_pwrite) o_hrdata <= rd_a[idx];
      cnt <= state == SETUP ? '0 : (state == ACCESS && !rdy) ? cnt + CW'(1) : cnt;
      flag <= (state == SLEEP && accept) ? 1'b1 : state == ERR2 ? 1'b0 : flag;
    end
  end
endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// tb_ahb_apb_bridge_mp: randomized and directed checks of the bridge against a transaction-level model
module tb_ahb_apb_bridge_mp;
  logic clk = 0, rst = 1, sleep_req = 0, no_sleep = 0, hsel0 = 0, hsel1 = 0, hready = 1, hwrite = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [127:0] prdata = 0;
  logic [3:0] pready = 0, pslverr = 0;
  logic [95:0] prdata1 = 0;
  logic [2:0] pready1 = 3'b111, pslverr1 = 0;
  logic ack0, hro0, hresp0, pen0, pwr0, ack1, hro1, hresp1, pen1, pwr1;
  logic [31:0] hrdata0, paddr0, pwdata0, hrdata1, paddr1, pwdata1;
  logic [3:0] psel0, pstrb0, pstrb1;
  logic [2:0] psel1;

  ahb_apb_bridge_mp #(.N_SLV(4), .TIMEOUT(8)) u0 (
    .i_clk(clk), .i_rst(rst), .i_sleep_req(sleep_req), .o_sleep_ack(ack0),
    .i_hselx(hsel0), .i_hready(hready), .i_htrans(htrans), .i_hsize(hsize), .i_hwrite(hwrite),
    .i_haddr(haddr), .i_hwdata(hwdata), .o_hreadyout(hro0), .o_hresp(hresp0), .o_hrdata(hrdata0),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr), .o_psel(psel0), .o_penable(pen0),
    .o_pwrite(pwr0), .o_paddr(paddr0), .o_pwdata(pwdata0), .o_pstrb(pstrb0));

  ahb_apb_bridge_mp #(.N_SLV(3), .TIMEOUT(8)) u1 (
    .i_clk(clk), .i_rst(rst), .i_sleep_req(no_sleep), .o_sleep_ack(ack1),
    .i_hselx(hsel1), .i_hready(hready), .i_htrans(htrans), .i_hsize(hsize), .i_hwrite(hwrite),
    .i_haddr(haddr), .i_hwdata(hwdata), .o_hreadyout(hro1), .o_hresp(hresp1), .o_hrdata(hrdata1),
    .i_prdata(prdata1), .i_pready(pready1), .i_pslverr(pslverr1), .o_psel(psel1), .o_penable(pen1),
    .o_pwrite(pwr1), .o_paddr(paddr1), .o_pwdata(pwdata1), .o_pstrb(pstrb1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct packed {
    int lows;
    int acc;
    logic [3:0] psel;
    logic [3:0] strb;
    logic resp;
  } exp_t;

  int checks = 0, passes = 0;
  int ob_lows, ob_acc;
  logic [3:0] ob_psel, ob_strb;
  logic [31:0] ob_paddr, ob_pwdata, ob_rdata, last_rd = 0;
  logic ob_pwrite, ob_err1, ob_resp, ob_stable, ob_ack_all;

  // Expected outcome of one transfer: hreadyout-low cycles, ACCESS cycles, select, strobes, response
  function automatic exp_t model(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                 input int waits, input logic serr, input logic slp, input int nslv);
    exp_t e;
    int idx, bytes;
    idx = int'(a[13:12]);
    bytes = 1 << sz;
    e = '0;
    e.resp = 1;
    if (slp) e.lows = 1;
    else if (idx >= nslv || bytes > 4) e.lows = 2;
    else begin
      e.psel = 4'(1 << idx);
      if (waits >= 8) begin
        e.acc = 8;
        e.lows = 11;
      end else begin
        e.acc = waits + 1;
        e.lows = 3 + waits + int'(serr);
        e.resp = serr;
      end
      if (w) e.strb = 4'(((1 << bytes) - 1) << ((a % 4) / bytes * bytes));
    end
    return e;
  endfunction

  // Drives one AHB transfer on u0 and plays the APB slave; records what the bridge did
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                      input int waits, input logic serr, input logic rs);
    int tgt = int'(a[13:12]);
    bit cap = 0;
    if (hresp0) @(negedge clk);
    hsel0 = 1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz; pready = 0; pslverr = 0;
    ob_lows = 0; ob_acc = 0; ob_psel = 0; ob_strb = 0; ob_paddr = 0; ob_pwdata = 0;
    ob_pwrite = 0; ob_err1 = 0; ob_stable = 1; ob_ack_all = 1;
    @(posedge clk);
    @(negedge clk);
    hsel0 = 0; htrans = 0; hwdata = wd;
    for (int c = 0; c < 40; c++) begin
      ob_ack_all &= ack0;
      if (hro0) break;
      ob_lows++;
      ob_err1 = hresp0;
      ob_psel |= psel0;
      if (psel0 != 0 && !cap) begin
        cap = 1; ob_paddr = paddr0; ob_pwdata = pwdata0; ob_strb = pstrb0; ob_pwrite = pwr0;
      end else if (psel0 != 0 && (paddr0 !== ob_paddr || pwdata0 !== ob_pwdata || pstrb0 !== ob_strb || pwr0 !== ob_pwrite))
        ob_stable = 0;
      pready = 0; pslverr = 0;
      if (pen0) begin
        ob_acc++;
        if (rs) sleep_req = 1;
        if (ob_acc == waits + 1) begin
          pready[tgt] = 1;
          pslverr[tgt] = serr;
        end
      end
      @(negedge clk);
    end
    pready = 0; pslverr = 0;
    ob_resp = hresp0;
    ob_rdata = hrdata0;
  endtask

  task automatic test_reset(input string tag);
    checks++; if (hro0 !== 1'b1) $display("FAIL %s hreadyout got %b exp 1", tag, hro0); else passes++;
    checks++; if ({hresp0, psel0, pen0, pwr0, pstrb0, ack0} !== '0)
      $display("FAIL %s ctrl got %b%b%b%b%b%b exp 0", tag, hresp0, psel0, pen0, pwr0, pstrb0, ack0); else passes++;
    checks++; if ({paddr0, pwdata0, hrdata0} !== '0)
      $display("FAIL %s data got %h %h %h exp 0", tag, paddr0, pwdata0, hrdata0); else passes++;
  endtask

  task automatic test_write;
    prdata = {$urandom, $urandom, $urandom, $urandom};
    xfer(32'h2004, 1, 2, 32'hDEADBEEF, 0, 0, 0);
    checks++; if (ob_psel !== 4'b0100) $display("FAIL wr psel got %b exp 0100", ob_psel); else passes++;
    checks++; if (ob_paddr !== 32'h2004) $display("FAIL wr paddr got %h exp 2004", ob_paddr); else passes++;
    checks++; if (ob_pwdata !== 32'hDEADBEEF) $display("FAIL wr pwdata got %h exp deadbeef", ob_pwdata); else passes++;
    checks++; if (ob_strb !== 4'hF) $display("FAIL wr pstrb got %h exp f", ob_strb); else passes++;
    checks++; if (ob_lows !== 3) $display("FAIL wr latency got %0d exp 3", ob_lows); else passes++;
    checks++; if (ob_resp !== 1'b0) $display("FAIL wr hresp got %b exp 0", ob_resp); else passes++;
  endtask

  task automatic test_read_wait;
    prdata = {$urandom, $urandom, 32'h11223344, $urandom};
    xfer(32'h1003, 0, 0, $urandom, 3, 0, 0);
    last_rd = 32'h11223344;
    checks++; if (ob_strb !== 4'h0) $display("FAIL rd pstrb got %h exp 0", ob_strb); else passes++;
    checks++; if (ob_acc !== 4) $display("FAIL rd access cycles got %0d exp 4", ob_acc); else passes++;
    checks++; if (ob_lows !== 6) $display("FAIL rd latency got %0d exp 6", ob_lows); else passes++;
    checks++; if (ob_rdata !== last_rd) $display("FAIL rd hrdata got %h exp %h", ob_rdata, last_rd); else passes++;
    checks++; if (ob_resp !== 1'b0) $display("FAIL rd hresp got %b exp 0", ob_resp); else passes++;
  endtask

  task automatic test_hw_slverr;
    xfer(32'h3002, 1, 1, $urandom, 0, 0, 0);
    checks++; if (ob_strb !== 4'b1100) $display("FAIL hw pstrb got %b exp 1100", ob_strb); else passes++;
    xfer(32'h3000, 0, 2, $urandom, 1, 1, 0);
    checks++; if (ob_lows !== 5) $display("FAIL slverr latency got %0d exp 5", ob_lows); else passes++;
    checks++; if ({ob_err1, ob_resp} !== 2'b11) $display("FAIL slverr hresp got %b%b exp 11", ob_err1, ob_resp); else passes++;
    checks++; if (ob_rdata !== last_rd) $display("FAIL slverr hrdata got %h exp %h", ob_rdata, last_rd); else passes++;
  endtask

  task automatic test_timeout;
    xfer(32'h0000, 0, 2, $urandom, 100, 0, 0);
    checks++; if (ob_acc !== 8) $display("FAIL tmo access cycles got %0d exp 8", ob_acc); else passes++;
    checks++; if (ob_lows !== 11) $display("FAIL tmo latency got %0d exp 11", ob_lows); else passes++;
    checks++; if ({ob_err1, ob_resp} !== 2'b11) $display("FAIL tmo hresp got %b%b exp 11", ob_err1, ob_resp); else passes++;
    checks++; if (ob_psel !== 4'b0001) $display("FAIL tmo psel got %b exp 0001", ob_psel); else passes++;
    prdata = {$urandom, $urandom, $urandom, $urandom};
    xfer(32'h0008, 0, 2, $urandom, 0, 0, 0);
    last_rd = prdata[31:0];
    checks++; if (ob_resp !== 1'b0) $display("FAIL post-tmo hresp got %b exp 0", ob_resp); else passes++;
    checks++; if (ob_rdata !== last_rd) $display("FAIL post-tmo hrdata got %h exp %h", ob_rdata, last_rd); else passes++;
  endtask

  task automatic test_decode_size;
    int lows = 0;
    logic [2:0] seen = 0;
    hsel1 = 1; htrans = 2'b10; haddr = 32'h3000; hwrite = 1; hsize = 2;
    @(posedge clk);
    @(negedge clk);
    hsel1 = 0; htrans = 0;
    for (int c = 0; c < 20; c++) begin
      if (hro1) break;
      lows++;
      seen |= psel1;
      @(negedge clk);
    end
    checks++; if (lows !== 2) $display("FAIL decode latency got %0d exp 2", lows); else passes++;
    checks++; if (seen !== 3'b000) $display("FAIL decode psel got %b exp 000", seen); else passes++;
    checks++; if (hresp1 !== 1'b1) $display("FAIL decode hresp got %b exp 1", hresp1); else passes++;
    @(negedge clk);
    xfer(32'h1000, 1, 3, $urandom, 0, 0, 0);
    checks++; if (ob_lows !== 2) $display("FAIL size latency got %0d exp 2", ob_lows); else passes++;
    checks++; if (ob_psel !== 4'b0000) $display("FAIL size psel got %b exp 0000", ob_psel); else passes++;
    checks++; if (ob_resp !== 1'b1) $display("FAIL size hresp got %b exp 1", ob_resp); else passes++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd;
      logic [2:0] sz;
      logic w, serr;
      int waits;
      exp_t e;
      a = ($urandom_range(0, 3) << 12) | $urandom_range(0, 4095);
      sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1));
      wd = $urandom;
      waits = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 4);
      serr = $urandom_range(0, 5) == 0;
      prdata = {$urandom, $urandom, $urandom, $urandom};
      e = model(a, w, sz, waits, serr, 0, 4);
      xfer(a, w, sz, wd, waits, serr, 0);
      if (!e.resp && !w) last_rd = prdata[int'(a[13:12])*32 +: 32];
      checks++; if (ob_lows !== e.lows) $display("FAIL rnd%0d latency got %0d exp %0d", i, ob_lows, e.lows); else passes++;
      checks++; if (ob_acc !== e.acc) $display("FAIL rnd%0d access got %0d exp %0d", i, ob_acc, e.acc); else passes++;
      checks++; if (ob_psel !== e.psel) $display("FAIL rnd%0d psel got %b exp %b", i, ob_psel, e.psel); else passes++;
      checks++; if ({ob_err1, ob_resp} !== {2{e.resp}}) $display("FAIL rnd%0d hresp got %b%b exp %b", i, ob_err1, ob_resp, e.resp); else passes++;
      checks++; if (ob_rdata !== last_rd) $display("FAIL rnd%0d hrdata got %h exp %h", i, ob_rdata, last_rd); else passes++;
      if (e.psel != 0) begin
        checks++; if (ob_strb !== e.strb) $display("FAIL rnd%0d pstrb got %b exp %b", i, ob_strb, e.strb); else passes++;
        checks++; if ({ob_paddr, ob_pwdata, ob_pwrite} !== {a, wd, w})
          $display("FAIL rnd%0d apb got %h %h %b exp %h %h %b", i, ob_paddr, ob_pwdata, ob_pwrite, a, wd, w); else passes++;
        checks++; if (ob_stable !== 1'b1) $display("FAIL rnd%0d apb stability got %b exp 1", i, ob_stable); else passes++;
      end
    end
  endtask

  task automatic test_sleep;
    exp_t e;
    xfer(32'h2010, 1, 2, $urandom, 3, 0, 1);
    checks++; if (ob_resp !== 1'b0) $display("FAIL slp-mid hresp got %b exp 0", ob_resp); else passes++;
    checks++; if (ack0 !== 1'b0) $display("FAIL slp-mid early ack got %b exp 0", ack0); else passes++;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) $display("FAIL slp ack rise got %b exp 1", ack0); else passes++;
    e = model(32'h1004, 0, 2, 0, 0, 1, 4);
    xfer(32'h1004, 0, 2, $urandom, 0, 0, 0);
    checks++; if (ob_lows !== e.lows) $display("FAIL slp-xfer latency got %0d exp %0d", ob_lows, e.lows); else passes++;
    checks++; if (ob_psel !== e.psel) $display("FAIL slp-xfer psel got %b exp %b", ob_psel, e.psel); else passes++;
    checks++; if (ob_resp !== e.resp) $display("FAIL slp-xfer hresp got %b exp %b", ob_resp, e.resp); else passes++;
    checks++; if (ob_ack_all !== 1'b1) $display("FAIL slp-xfer ack got %b exp 1", ob_ack_all); else passes++;
    @(negedge clk);
    checks++; if (ack0 !== 1'b1) $display("FAIL slp ack hold got %b exp 1", ack0); else passes++;
    sleep_req = 0;
    @(negedge clk);
    checks++; if (ack0 !== 1'b0) $display("FAIL slp ack fall got %b exp 0", ack0); else passes++;
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    hsel0 = 1; htrans = 2'b10; haddr = 32'h1004; hwrite = 0; hsize = 2; pready = 0;
    @(posedge clk);
    @(negedge clk);
    hsel0 = 0; htrans = 0;
    for (int c = 0; c < 10; c++) begin
      if (pen0) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (seen !== 1'b1) $display("FAIL rst-mid reach access got %b exp 1", seen); else passes++;
    rst = 1;
    #1;
    test_reset("rst-mid");
    @(negedge clk);
    rst = 0;
    last_rd = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset("reset");
    test_write;
    test_read_wait;
    test_hw_slverr;
    test_timeout;
    test_decode_size;
    test_random;
    test_sleep;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
